// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan monitor.
// Segment codes are active low in the order {a,b,c,d,e,f,g}.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
  } sample_t;

  // True when exactly one active-low anode line is driven.
  function automatic logic one_low(input logic [NUM_DIGITS-1:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps an active-low segment pattern back to its hex nibble.
// hit flags a table match; blank flags the all-segments-off pattern.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    blank  = (code == SEG_BLANK);
    case (code)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_monitor.sv
// Watches a multiplexed seven-segment bus, rebuilds the displayed digits
// and reports frame completion, undecodable patterns and anode overlap.
module seg_scan_monitor
  import seg_scan_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   bad_mask,
  output logic                    anode_err,
  output logic                    frame_done,
  output logic [15:0]             frame_count
);

  localparam logic [15:0] CAP_AT = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] SAT_AT = 16'(STABLE_CYCLES);

  sample_t                     cur_sample;
  sample_t                     sample_reg;
  logic                        primed_reg;
  logic [15:0]                 cnt_reg;
  logic [NUM_DIGITS-1:0][3:0]  digits_reg;
  logic [NUM_DIGITS-1:0]       valid_reg;
  logic [NUM_DIGITS-1:0]       bad_reg;
  logic [NUM_DIGITS-1:0]       seen_reg;
  logic [NUM_DIGITS-1:0]       seen_next;
  logic                        anode_err_reg;
  logic                        frame_done_reg;
  logic [15:0]                 frame_count_reg;

  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       dec_blank;
  logic       capture;
  logic       single_low;
  logic       multi_low;
  logic       cap_digit;
  logic       frame_pulse;

  assign cur_sample = '{an: an_in, seg: seg_in};

  // primed_reg keeps the cleared sample register from counting as a
  // previous value, so the first sample after reset opens a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg <= '0;
      primed_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sample_reg <= cur_sample;
      primed_reg <= 1'b1;
      if (!primed_reg || cur_sample != sample_reg)
        cnt_reg <= '0;
      else if (cnt_reg != SAT_AT)
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  seg_pattern_decode u_decode (
    .code   (sample_reg.seg),
    .nibble (dec_nibble),
    .hit    (dec_hit),
    .blank  (dec_blank)
  );

  assign capture     = (cnt_reg == CAP_AT);
  assign single_low  = one_low(sample_reg.an);
  assign multi_low   = !single_low && (sample_reg.an != '1);
  assign cap_digit   = capture && single_low;
  assign frame_pulse = (seen_reg == '1);
  assign seen_next   = (frame_pulse ? '0 : seen_reg)
                     | (cap_digit ? ~sample_reg.an : '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      always_ff @(posedge clk) begin
        if (reset) begin
          digits_reg[gi] <= 4'h0;
          valid_reg[gi]  <= 1'b0;
          bad_reg[gi]    <= 1'b0;
        end else if (cap_digit && !sample_reg.an[gi]) begin
          if (dec_hit) begin
            digits_reg[gi] <= dec_nibble;
            valid_reg[gi]  <= 1'b1;
          end else begin
            valid_reg[gi] <= 1'b0;
            if (!dec_blank)
              bad_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  // A capture landing on the frame_done edge seeds the next frame's mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      seen_reg        <= '0;
      anode_err_reg   <= 1'b0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      seen_reg       <= seen_next;
      frame_done_reg <= frame_pulse;
      if (frame_pulse)
        frame_count_reg <= frame_count_reg + 16'd1;
      if (capture && multi_low)
        anode_err_reg <= 1'b1;
    end
  end

  assign digits      = digits_reg;
  assign digit_valid = valid_reg;
  assign bad_mask    = bad_reg;
  assign anode_err   = anode_err_reg;
  assign frame_done  = frame_done_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed bench for seg_scan_monitor: scans, capture timing, error flags,
// mid-scan reset and frame counter wrap.
module tb_seg_scan_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  bad_mask;
  logic        anode_err;
  logic        frame_done;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd_base;

  logic [6:0] seg_code [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                                7'h20, 7'h0F, 7'h00, 7'h04, 7'h08, 7'h60,
                                7'h31, 7'h42, 7'h30, 7'h38};

  seg_scan_monitor #(.STABLE_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .digit_valid (digit_valid),
    .bad_mask    (bad_mask),
    .anode_err   (anode_err),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Hold a pattern for n rising edges; returns at a falling edge.
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] val, input int ndig, input int n);
    for (int i = 0; i < ndig; i++)
      drive(~(8'd1 << i), seg_code[val[4*i +: 4]], n);
  endtask

  initial begin
    reset  = 1'b1;
    an_in  = 8'hFF;
    seg_in = 7'h7F;
    @(negedge clk);
    repeat (10) begin
      an_in  = 8'($urandom);
      seg_in = 7'($urandom);
      @(negedge clk);
    end
    check("rst_digits", digits, 32'h0);
    check("rst_flags", {8'h0, digit_valid, bad_mask, 6'h0, anode_err, frame_done}, 32'h0);
    check("rst_count", {16'h0, frame_count}, 32'h0);

    reset   = 1'b0;
    fd_base = fd_cnt;
    drive(8'hFF, 7'h7F, 100);
    check("blank_digits", digits, 32'h0);
    check("blank_valid", {24'h0, digit_valid}, 32'h0);
    check("blank_fd", fd_cnt - fd_base, 0);
    check("blank_count", {16'h0, frame_count}, 32'h0);

    fd_base = fd_cnt;
    scan(32'h87654321, 8, 20);
    check("scan_digits", digits, 32'h87654321);
    check("scan_valid", {24'h0, digit_valid}, 32'hFF);
    check("scan_fd", fd_cnt - fd_base, 1);
    check("scan_count", {16'h0, frame_count}, 32'h1);

    drive(8'hFE, 7'h38, 20);
    check("d0_F", {28'h0, digits[3:0]}, 32'hF);
    drive(8'hFE, 7'h01, 15);
    check("short_win", {28'h0, digits[3:0]}, 32'hF);
    drive(8'hFE, 7'h4F, 16);
    check("pre_edge", {28'h0, digits[3:0]}, 32'hF);
    drive(8'hFE, 7'h4F, 1);
    check("at_edge", {28'h0, digits[3:0]}, 32'h1);

    drive(8'hFC, 7'h00, 20);
    check("anode_err", {31'h0, anode_err}, 32'h1);
    check("anode_digits", digits, 32'h87654321);
    drive(8'hEF, 7'h55, 20);
    check("bad_mask", {24'h0, bad_mask}, 32'h10);
    check("bad_valid", {24'h0, digit_valid}, 32'hEF);
    drive(8'hFD, 7'h7F, 20);
    check("blank_d1_valid", {24'h0, digit_valid}, 32'hED);
    check("blank_d1_bad", {24'h0, bad_mask}, 32'h10);
    check("blank_d1_digits", digits, 32'h87654321);

    scan(32'h00000BA9, 3, 20);
    drive(8'hF7, seg_code[12], 8);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_digits", digits, 32'h0);
    check("mid_rst_flags", {8'h0, digit_valid, bad_mask, 6'h0, anode_err, frame_done}, 32'h0);
    check("mid_rst_count", {16'h0, frame_count}, 32'h0);
    reset   = 1'b0;
    fd_base = fd_cnt;
    scan(32'h43210FED, 8, 20);
    check("post_rst_digits", digits, 32'h43210FED);
    check("post_rst_count", {16'h0, frame_count}, 32'h1);
    check("post_rst_fd", fd_cnt - fd_base, 1);

    force dut.frame_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_reg;
    @(negedge clk);
    check("preset_count", {16'h0, frame_count}, 32'hFFFF);
    fd_base = fd_cnt;
    scan(32'h12345678, 8, 20);
    check("wrap_count", {16'h0, frame_count}, 32'h0);
    check("wrap_fd", fd_cnt - fd_base, 1);
    check("wrap_digits", digits, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_monitor.md
Name: seg_scan_monitor

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment driver: watches the active-low segment lines (a..g) and anode lines (aa7..aa0) that the counter top level drives.
- Reconstructs the hex value shown on each digit and reports per-frame completion plus pattern and anode errors.
- Sits beside the display driver in the top level and benches, as an on-chip display checker. Single clock domain.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles an {anode, segment} pair must hold before it is captured. Legal range 2..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; clears all state.
- seg_in  in  7  segment lines, active low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an_in  in  8  anode lines, active low; bit i = aa_i.
- digits  out  32  captured nibbles; digits[4i+3:4i] = digit i.
- digit_valid  out  8  bit i set = digit i holds a decoded hex value.
- bad_mask  out  8  sticky; bit i set = undecodable pattern seen on digit i.
- anode_err  out  1  sticky; more than one anode low during a stable window.
- frame_done  out  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- frame_count  out  16  number of frame_done pulses; wraps 0xFFFF->0x0000.

Behaviour:
- Reset values: digits=0, digit_valid=0, bad_mask=0, anode_err=0, frame_done=0, frame_count=0. Internal sample register, stability counter and seen-mask also cleared.
- A reset mid-window discards the partial window. The first sample after reset starts a new window.
- Input sampling: {an_in, seg_in} registered every edge.
  - Stability counter resets to 0 when the registered value differs from the previous registered value.
  - Otherwise it increments, saturating at STABLE_CYCLES.
- Capture: exactly one capture per stable window, at the edge where the counter reaches STABLE_CYCLES-1. Inputs held from edge E0 produce the output update at edge E0+STABLE_CYCLES. A window that never reaches STABLE_CYCLES produces nothing.
- At capture, by anode pattern:
  - All anodes high (0xFF): blank period; no update.
  - More than one anode low: set anode_err; no digit update.
  - Exactly one anode low (digit i): decode seg_in per the table below.
- Decode table, seg_in hex -> nibble: 0x01->0, 0x4F->1, 0x12->2, 0x06->3, 0x4C->4, 0x24->5, 0x20->6, 0x0F->7, 0x00->8, 0x04->9, 0x08->A, 0x60->b, 0x31->C, 0x42->d, 0x30->E, 0x38->F.
- Result of the decode for digit i:
  - Code in the table: digits[i] <= nibble, digit_valid[i] <= 1.
  - 0x7F (all segments off): digit_valid[i] <= 0; digits[i] unchanged; not an error.
  - Any other code: bad_mask[i] <= 1, digit_valid[i] <= 0, digits[i] unchanged.
  - In all three cases, seen-mask bit i is set.
- Frame tracking:
  - When the seen-mask becomes 0xFF, frame_done pulses on the next edge, frame_count increments, and the seen-mask clears on that same edge.
  - A capture on the pulse edge is counted toward the new frame.
  - Repeated captures of the same digit within a frame are allowed; each overwrites the previous.
- Sticky flags clear only on reset.

Decomposition:
- Package seg_scan_pkg:
  - the 16 segment-code constants;
  - the blank code 0x7F;
  - a one-hot-low check function;
  - NUM_DIGITS=8.
- Sub-module seg_pattern_decode (combinational): input 7-bit code; outputs nibble, hit and blank. Instantiated once.
- Everything else in one sequential module: sample register, stability counter, capture logic, seen-mask, frame counter.

Test Plan:
- Reset held 10 cycles with random inputs -> all outputs 0. Release, then drive an=0xFF, seg=0x7F for 100 cycles -> no update, frame_done never asserts.
- Scan digits 0..7 with codes for 1,2,3,4,5,6,7,8, 20 cycles each (STABLE_CYCLES=16), anode low for the matching digit -> digits=0x87654321, digit_valid=0xFF, single frame_done pulse, frame_count=1.
- Hold an=0xFE, seg=0x01 for 15 cycles, then switch to seg=0x4F -> no capture of 0. Holding 0x4F for 16 cycles -> digits[3:0]=1, updated exactly at E0+16.
- an=0xFC with seg=0x00 for 20 cycles -> anode_err=1, digits unchanged. an=0xEF with seg=0x55 for 20 cycles -> bad_mask=0x10, digit_valid[4]=0.
- Assert reset for 1 cycle midway through the fourth digit of a scan -> all outputs 0 next cycle. A subsequent full 8-digit scan yields frame_count=1.
- Force frame_count to 0xFFFF via 65535 frames (or a fast scan with STABLE_CYCLES=2) -> next frame_done wraps it to 0x0000.
